aes_gcm_output_stage: RTL and testbench



---
 rtl/aes_gcm_pkg.sv | 27 ++
 rtl/aes_block_fifo.sv | 63 ++++++
 rtl/aes_gcm_output_stage.sv | 182 ++++++++++++++++++
 tb/tb_aes_gcm_output_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_gcm_pkg.sv
// aes_gcm_pkg
// Shared types and helpers for the AES-GCM output stage.
//   block_t     : one 128-bit block, bit 0 is the most significant bit
//   out_state_t : output sequencing FSM states
//   BLOCK_BITS  : block width
//   tag_mask()  : ones on the leading 'bits' positions, zeros after
package aes_gcm_pkg;

  localparam int BLOCK_BITS = 128;

  typedef logic [0:BLOCK_BITS-1] block_t;

  typedef enum logic [1:0] {
    S_DATA     = 2'd0,
    S_TAG_PEND = 2'd1,
    S_TAG_OUT  = 2'd2
  } out_state_t;

  function automatic block_t tag_mask(input int bits);
    block_t m;
    for (int i = 0; i < BLOCK_BITS; i++) begin
      m[i] = (i < bits);
    end
    return m;
  endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// aes_block_fifo
// Block-wide FIFO with registered storage. The head entry is read directly
// from the storage array, so a block pushed at one edge is visible on dout
// (with empty=0) right after that edge.
// Ports:
//   clk, rst      clock, synchronous active-high reset (flushes pointers)
//   push, din     write request and data; ignored when full unless pop
//   pop           read request; ignored when empty
//   dout          current head entry
//   full, empty   status
//   count         occupancy, 0..DEPTH
module aes_block_fifo
  import aes_gcm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  block_t                   din,
  output block_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  block_t         mem [DEPTH];
  logic [CW-1:0]  wr_ptr;
  logic [CW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Pointers carry one extra wrap bit: equal low bits with differing MSB
  // means the write side has lapped the read side.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/aes_gcm_output_stage.sv
// aes_gcm_output_stage
// Output stage after the GHASH/tag stage. Buffers the free-running
// cipher-text stream in a FIFO, holds the final tag, and emits all
// cipher-text blocks of an instance followed by one tag beat on a
// valid/ready interface.
// Optional build macro: AES_GCM_TAG_COMPARE_EN
//   defined   : tag is compared against i_expected_tag, tag beat data is
//               forced to zero, mismatch raises sticky o_auth_fail
//   undefined : tag emitted normally, o_auth_fail tied to 0
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_cipher_text    cipher-text block, qualified by i_ct_valid
//   i_tag            tag, final when i_tag_ready pulses
//   i_expected_tag   reference tag (compare build only)
//   o_data, o_valid  output beat, handshake with i_ready
//   o_is_tag         current beat is the tag
//   o_overflow       sticky: block dropped on full FIFO or tag lost
//   o_auth_fail      sticky: tag compare mismatch
//
// state      | meaning
// S_DATA     | stream FIFO blocks, wait for a tag
// S_TAG_PEND | tag held, draining blocks that precede it
// S_TAG_OUT  | presenting the tag beat
module aes_gcm_output_stage
  import aes_gcm_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_BITS   = 128
) (
  input  logic   clk,
  input  logic   rst,
  input  block_t i_cipher_text,
  input  logic   i_ct_valid,
  input  block_t i_tag,
  input  logic   i_tag_ready,
  input  block_t i_expected_tag,
  output block_t o_data,
  output logic   o_valid,
  input  logic   i_ready,
  output logic   o_is_tag,
  output logic   o_overflow,
  output logic   o_auth_fail
);

  localparam int     CW       = $clog2(FIFO_DEPTH) + 1;
  localparam block_t TAG_MASK = tag_mask(TAG_BITS);

  out_state_t    state;
  block_t        tag_q;
  logic [CW-1:0] pre_cnt;
  logic          overflow_q;

  block_t        fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          xfer;
  logic          pop;
  logic          push;
  logic          ct_drop;
  logic          tag_xfer;
  logic [CW-1:0] occ_next;
  block_t        tag_beat;

  assign xfer     = o_valid && i_ready;
  assign pop      = xfer && (state != S_TAG_OUT);
  assign tag_xfer = xfer && (state == S_TAG_OUT);
  // A push on a full FIFO is only accepted when the head leaves this cycle.
  assign push     = i_ct_valid && (!fifo_full || pop);
  assign ct_drop  = i_ct_valid && fifo_full && !pop;
  // Occupancy after this edge: the pre-tag count includes a same-cycle push.
  assign occ_next = fifo_count + CW'(push) - CW'(pop);

  aes_block_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (i_cipher_text),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef AES_GCM_TAG_COMPARE_EN
  logic mismatch;
  logic mis_q;
  logic auth_fail_q;

  assign mismatch = |((i_tag ^ i_expected_tag) & TAG_MASK);
  // The computed tag must never appear on the output in this build.
  assign tag_beat = '0;
  assign o_auth_fail = auth_fail_q;
`else
  logic unused_expected;

  assign unused_expected = ^i_expected_tag;
  assign tag_beat = tag_q & TAG_MASK;
  assign o_auth_fail = 1'b0;
`endif

  // Blocks behind a pending tag belong to the next instance; they stay
  // hidden until the tag has gone out.
  always_comb begin
    o_valid = 1'b0;
    case (state)
      S_DATA:     o_valid = !fifo_empty;
      S_TAG_PEND: o_valid = !fifo_empty && (pre_cnt != '0);
      S_TAG_OUT:  o_valid = 1'b1;
      default:    o_valid = 1'b0;
    endcase
  end

  assign o_is_tag   = (state == S_TAG_OUT);
  assign o_data     = !o_valid ? '0 : (o_is_tag ? tag_beat : fifo_head);
  assign o_overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_DATA;
      tag_q      <= '0;
      pre_cnt    <= '0;
      overflow_q <= 1'b0;
`ifdef AES_GCM_TAG_COMPARE_EN
      mis_q       <= 1'b0;
      auth_fail_q <= 1'b0;
`endif
    end else begin
      if (ct_drop) overflow_q <= 1'b1;

      case (state)
        S_DATA: begin
          if (i_tag_ready) begin
            tag_q   <= i_tag;
            pre_cnt <= occ_next;
            state   <= S_TAG_PEND;
`ifdef AES_GCM_TAG_COMPARE_EN
            mis_q   <= mismatch;
`endif
          end
        end

        S_TAG_PEND: begin
          if (i_tag_ready) overflow_q <= 1'b1;
          if (pop) pre_cnt <= pre_cnt - CW'(1);
          if ((pre_cnt == '0) || ((pre_cnt == CW'(1)) && pop)) begin
            state <= S_TAG_OUT;
          end
        end

        S_TAG_OUT: begin
          if (tag_xfer) begin
`ifdef AES_GCM_TAG_COMPARE_EN
            if (mis_q) auth_fail_q <= 1'b1;
`endif
            if (i_tag_ready) begin
              // Back-to-back tag: nothing popped this cycle, so the
              // occupancy plus any push is exactly the next pre-tag count.
              tag_q   <= i_tag;
              pre_cnt <= occ_next;
              state   <= S_TAG_PEND;
`ifdef AES_GCM_TAG_COMPARE_EN
              mis_q   <= mismatch;
`endif
            end else begin
              state <= S_DATA;
            end
          end else if (i_tag_ready) begin
            overflow_q <= 1'b1;
          end
        end

        default: state <= S_DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_gcm_output_stage.sv
module tb_aes_gcm_output_stage;
  import aes_gcm_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  block_t i_cipher_text;
  logic   i_ct_valid;
  block_t i_tag;
  logic   i_tag_ready;
  block_t i_expected_tag;
  logic   i_ready;
  block_t o_data;
  logic   o_valid;
  logic   o_is_tag;
  logic   o_overflow;
  logic   o_auth_fail;
  block_t o_data96;
  logic   o_valid96;
  logic   o_is_tag96;
  logic   o_overflow96;
  logic   o_auth_fail96;

  int n_vec = 0;
  int n_err = 0;

  block_t got_d[$];
  logic   got_t[$];

  always #5 clk = ~clk;

  aes_gcm_output_stage #(.FIFO_DEPTH(8), .TAG_BITS(128)) dut (
    .clk(clk), .rst(rst), .i_cipher_text(i_cipher_text), .i_ct_valid(i_ct_valid),
    .i_tag(i_tag), .i_tag_ready(i_tag_ready), .i_expected_tag(i_expected_tag),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_is_tag(o_is_tag),
    .o_overflow(o_overflow), .o_auth_fail(o_auth_fail)
  );

  aes_gcm_output_stage #(.FIFO_DEPTH(8), .TAG_BITS(96)) dut96 (
    .clk(clk), .rst(rst), .i_cipher_text(i_cipher_text), .i_ct_valid(i_ct_valid),
    .i_tag(i_tag), .i_tag_ready(i_tag_ready), .i_expected_tag(i_expected_tag),
    .o_data(o_data96), .o_valid(o_valid96), .i_ready(i_ready), .o_is_tag(o_is_tag96),
    .o_overflow(o_overflow96), .o_auth_fail(o_auth_fail96)
  );

  typedef struct {
    logic   ct_valid;
    block_t ct;
    logic   tag_ready;
    block_t tag;
    logic   ready;
    logic   exp_valid;
    block_t exp_data;
    logic   exp_is_tag;
  } vec_t;

  function automatic block_t blk(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic block_t tag_exp128(input block_t t);
`ifdef AES_GCM_TAG_COMPARE_EN
    return '0;
`else
    return t;
`endif
  endfunction

  function automatic block_t tag_exp96(input block_t t);
    block_t m;
    m = {{96{1'b1}}, {32{1'b0}}};
`ifdef AES_GCM_TAG_COMPARE_EN
    return '0;
`else
    return t & m;
`endif
  endfunction

  function automatic vec_t mkv(input logic cv, input block_t ct, input logic tr, input block_t tg,
                               input logic rdy, input logic ev, input block_t ed, input logic et);
    vec_t v;
    v.ct_valid = cv; v.ct = ct; v.tag_ready = tr; v.tag = tg; v.ready = rdy;
    v.exp_valid = ev; v.exp_data = ed; v.exp_is_tag = et;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_ct_valid = 1'b0; i_tag_ready = 1'b0; i_ready = 1'b0;
    i_cipher_text = '0; i_tag = '0; i_expected_tag = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_blk(input block_t b);
    @(negedge clk);
    i_ct_valid = 1'b1; i_cipher_text = b; i_tag_ready = 1'b0;
  endtask

  // Raises ready and gathers up to n beats from the 128-bit instance.
  task automatic collect(input int n, input int budget);
    got_d.delete(); got_t.delete();
    for (int c = 0; c < budget && got_d.size() < n; c++) begin
      @(negedge clk);
      i_ct_valid = 1'b0; i_tag_ready = 1'b0; i_ready = 1'b1;
      if (o_valid) begin
        got_d.push_back(o_data);
        got_t.push_back(o_is_tag);
      end
    end
    if (got_d.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL collect: got %0d beats expected %0d", got_d.size(), n);
    end
  endtask

  task automatic check_beats(input string name, input block_t exp_d[$], input logic exp_t[$]);
    for (int k = 0; k < exp_d.size(); k++) begin
      if (k < got_d.size()) begin
        check($sformatf("%s_data%0d", name, k), got_d[k], exp_d[k]);
        check($sformatf("%s_is_tag%0d", name, k), {127'b0, got_t[k]}, {127'b0, exp_t[k]});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t   vecs[13];
    block_t exp_d[$];
    logic   exp_t[$];
    block_t ones;
    block_t exp_ref;
    logic   stable;
    logic   seen;
    logic   exp_auth;

    rst = 1'b1; i_ct_valid = 1'b0; i_tag_ready = 1'b0; i_ready = 1'b0;
    i_cipher_text = '0; i_tag = '0; i_expected_tag = '0;

    // Ordering: three blocks then a tag, sink always ready.
    vecs[0]  = mkv(1, blk(8'h01), 0, '0,         1, 0, '0,                    0);
    vecs[1]  = mkv(1, blk(8'h02), 0, '0,         1, 1, blk(8'h01),            0);
    vecs[2]  = mkv(1, blk(8'h03), 0, '0,         1, 1, blk(8'h02),            0);
    vecs[3]  = mkv(0, '0,         1, blk(8'hAA), 1, 1, blk(8'h03),            0);
    vecs[4]  = mkv(0, '0,         0, '0,         1, 0, '0,                    0);
    vecs[5]  = mkv(0, '0,         0, '0,         1, 1, tag_exp128(blk(8'hAA)), 1);
    vecs[6]  = mkv(0, '0,         0, '0,         1, 0, '0,                    0);
    // Same-cycle tag: block 2 pushed with the tag, next instance follows.
    vecs[7]  = mkv(1, blk(8'h11), 0, '0,         1, 0, '0,                    0);
    vecs[8]  = mkv(1, blk(8'h22), 1, blk(8'h77), 1, 1, blk(8'h11),            0);
    vecs[9]  = mkv(1, blk(8'h55), 0, '0,         1, 1, blk(8'h22),            0);
    vecs[10] = mkv(0, '0,         0, '0,         1, 1, tag_exp128(blk(8'h77)), 1);
    vecs[11] = mkv(0, '0,         0, '0,         1, 1, blk(8'h55),            0);
    vecs[12] = mkv(0, '0,         0, '0,         1, 0, '0,                    0);

    do_reset();
    check("reset_data", o_data, '0);
    check("reset_flags", {124'b0, o_valid, o_is_tag, o_overflow, o_auth_fail}, '0);

    for (int i = 0; i < 13; i++) begin
      if (i == 0 || i == 7) do_reset();
      @(negedge clk);
      i_ct_valid = vecs[i].ct_valid; i_cipher_text = vecs[i].ct;
      i_tag_ready = vecs[i].tag_ready; i_tag = vecs[i].tag; i_ready = vecs[i].ready;
      check($sformatf("vec%0d_valid", i), {127'b0, o_valid}, {127'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_data", i), o_data, vecs[i].exp_data);
      check($sformatf("vec%0d_is_tag", i), {127'b0, o_is_tag}, {127'b0, vecs[i].exp_is_tag});
    end

    // Backpressure: 5 blocks and a tag held for 10 cycles.
    do_reset();
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      i_ready = 1'b0;
      i_ct_valid = (c < 5);
      i_cipher_text = blk(8'h31 + 8'(c));
      i_tag_ready = (c == 5);
      i_tag = blk(8'hC3);
      if (c >= 1 && !(o_valid === 1'b1 && o_data === blk(8'h31) && o_is_tag === 1'b0)) stable = 1'b0;
    end
    check("bp_stable", {127'b0, stable}, 128'd1);
    collect(6, 20);
    exp_d.delete(); exp_t.delete();
    for (int k = 0; k < 5; k++) begin exp_d.push_back(blk(8'h31 + 8'(k))); exp_t.push_back(1'b0); end
    exp_d.push_back(tag_exp128(blk(8'hC3))); exp_t.push_back(1'b1);
    check_beats("bp", exp_d, exp_t);
    check("bp_overflow", {127'b0, o_overflow}, '0);

    // Overflow: 9 blocks into an 8-deep FIFO with the sink stalled.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      push_blk(blk(8'h41 + 8'(k)));
      if (k == 8) check("ovf_before", {127'b0, o_overflow}, '0);
    end
    @(negedge clk);
    i_ct_valid = 1'b0;
    check("ovf_set", {127'b0, o_overflow}, 128'd1);
    collect(8, 20);
    exp_d.delete(); exp_t.delete();
    for (int k = 0; k < 8; k++) begin exp_d.push_back(blk(8'h41 + 8'(k))); exp_t.push_back(1'b0); end
    check_beats("ovf", exp_d, exp_t);
    @(negedge clk);
    i_ready = 1'b1;
    check("ovf_dropped", {127'b0, o_valid}, '0);
    check("ovf_sticky", {127'b0, o_overflow}, 128'd1);

    // Full FIFO with simultaneous push and pop is not an overflow.
    do_reset();
    for (int k = 0; k < 8; k++) push_blk(blk(8'h61 + 8'(k)));
    @(negedge clk);
    i_ct_valid = 1'b1; i_cipher_text = blk(8'h69); i_ready = 1'b1;
    collect(8, 20);
    exp_d.delete(); exp_t.delete();
    for (int k = 0; k < 8; k++) begin exp_d.push_back(blk(8'h62 + 8'(k))); exp_t.push_back(1'b0); end
    check_beats("fullpp", exp_d, exp_t);
    check("fullpp_overflow", {127'b0, o_overflow}, '0);

    // Second tag while one is pending: overflow, first tag kept.
    do_reset();
    push_blk(blk(8'h71));
    @(negedge clk);
    i_ct_valid = 1'b0; i_tag_ready = 1'b1; i_tag = blk(8'h81);
    @(negedge clk);
    i_tag_ready = 1'b1; i_tag = blk(8'h82);
    @(negedge clk);
    i_tag_ready = 1'b0;
    check("tag2_overflow", {127'b0, o_overflow}, 128'd1);
    collect(2, 10);
    exp_d.delete(); exp_t.delete();
    exp_d.push_back(blk(8'h71)); exp_t.push_back(1'b0);
    exp_d.push_back(tag_exp128(blk(8'h81))); exp_t.push_back(1'b1);
    check_beats("tag2", exp_d, exp_t);

    // Truncated tag and tag compare: reference differs only in bit 127.
    do_reset();
    ones = '1;
    exp_ref = ones;
    exp_ref[127] = 1'b0;
    @(negedge clk);
    i_ready = 1'b1; i_tag_ready = 1'b1; i_tag = ones; i_expected_tag = exp_ref;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      i_tag_ready = 1'b0;
      if (o_valid96) begin
        seen = 1'b1;
        check("t96_data", o_data96, tag_exp96(ones));
        check("t96_is_tag", {127'b0, o_is_tag96}, 128'd1);
        check("t128_data", o_data, tag_exp128(ones));
      end
    end
    check("t96_seen", {127'b0, seen}, 128'd1);
    @(negedge clk);
`ifdef AES_GCM_TAG_COMPARE_EN
    exp_auth = 1'b1;
`else
    exp_auth = 1'b0;
`endif
    check("auth128", {127'b0, o_auth_fail}, {127'b0, exp_auth});
    check("auth96", {127'b0, o_auth_fail96}, '0);

    // Reset mid-stream clears FIFO, pending tag and sticky flags.
    i_ready = 1'b0;
    for (int k = 0; k < 9; k++) push_blk(blk(8'h90 + 8'(k)));
    @(negedge clk);
    i_ct_valid = 1'b0; i_tag_ready = 1'b1; i_tag = blk(8'hEE);
    @(negedge clk);
    i_tag_ready = 1'b0;
    check("mid_pre_flags", {125'b0, o_valid, o_overflow, o_auth_fail}, {125'b0, 1'b1, 1'b1, exp_auth});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_data", o_data, '0);
    check("mid_rst_flags", {124'b0, o_valid, o_is_tag, o_overflow, o_auth_fail}, '0);
    @(negedge clk);
    check("mid_rst_empty", {127'b0, o_valid}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
